// File: rtl/fact_pkg.sv
// fact_pkg: register map, STATUS bit positions and engine states shared by the
// fact_queue_core slice.
package fact_pkg;

    localparam logic [5:0] OFS_OPSTART    = 6'h00;
    localparam logic [5:0] OFS_OPCLEAR    = 6'h08;
    localparam logic [5:0] OFS_STATUS     = 6'h10;
    localparam logic [5:0] OFS_INTR_EN    = 6'h18;
    localparam logic [5:0] OFS_OPERAND    = 6'h20;
    localparam logic [5:0] OFS_RESULT_H   = 6'h28;
    localparam logic [5:0] OFS_RESULT_L   = 6'h30;
    localparam logic [5:0] OFS_RESULT_POP = 6'h38;

    localparam int unsigned ST_ALL_DONE  = 0;
    localparam int unsigned ST_BUSY      = 1;
    localparam int unsigned ST_IN_FULL   = 2;
    localparam int unsigned ST_OUT_EMPTY = 3;
    localparam int unsigned ST_OVF       = 4;
    localparam int unsigned ST_DROP      = 5;
    localparam int unsigned ST_IN_CNT    = 8;
    localparam int unsigned ST_OUT_CNT   = 16;

    typedef enum logic [1:0] {IDLE, LOAD, MUL, WRITE} eng_state_e;

endpackage

// File: rtl/fact_fifo.sv
// fact_fifo: synchronous FIFO with flush; pushes while full and pops while
// empty are ignored, and a simultaneous push and pop leaves the count unchanged.
module fact_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !reset && !clear) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/fact_queue_core.sv
// fact_queue_core: bus slave feeding an iterative factorial engine through operand and
// result FIFOs. Define FACTO_OVF_DETECT_EN to build the wide product and sticky ovf flag.
module fact_queue_core
    import fact_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'h7000,
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned RES_W     = 2 * DATA_W,
    parameter int unsigned DEPTH     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_sel,
    input  logic              s_wr,
    input  logic [15:0]       s_addr,
    input  logic [DATA_W-1:0] s_din,
    output logic [DATA_W-1:0] s_dout,
    output logic              interrupt
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [5:0]        ofs;
    logic              hit, wr_en, rd_en;
    logic              opstart_w, opclear_w, intr_w, operand_w, pop_w;
    logic              run, all_done, intr_en, ovf, drop;
    eng_state_e        state;
    logic [RES_W-1:0]  acc;
    logic [DATA_W-1:0] cnt;
    logic [RES_W-1:0]  prod;
    logic              prod_ovf;

    logic              in_push, in_pop, in_full, in_empty;
    logic [DATA_W-1:0] in_head;
    logic [CW-1:0]     in_count;
    logic              out_push, out_pop, out_full, out_empty;
    logic [RES_W-1:0]  out_head;
    logic [CW-1:0]     out_count;
    logic [DATA_W-1:0] status, rdata;

    assign ofs       = s_addr[5:0];
    assign hit       = s_sel && (s_addr[15:6] == BASE_ADDR[15:6]);
    assign wr_en     = hit && s_wr;
    assign rd_en     = hit && !s_wr;
    assign opstart_w = wr_en && (ofs == OFS_OPSTART) && s_din[0];
    assign opclear_w = wr_en && (ofs == OFS_OPCLEAR) && s_din[0];
    assign intr_w    = wr_en && (ofs == OFS_INTR_EN);
    assign operand_w = wr_en && (ofs == OFS_OPERAND);
    assign pop_w     = wr_en && (ofs == OFS_RESULT_POP) && s_din[0];

    // OPCLEAR wins over every FIFO movement in the same cycle.
    assign in_push   = operand_w && !in_full && !opclear_w;
    assign in_pop    = (state == IDLE) && run && !in_empty && !out_full && !opclear_w;
    assign out_push  = (state == WRITE) && !opclear_w;
    assign out_pop   = pop_w && !out_empty && !opclear_w;
    assign interrupt = intr_en && all_done;

    fact_fifo #(.WIDTH(DATA_W), .DEPTH(DEPTH)) u_in_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (opclear_w),
        .push  (in_push),
        .pop   (in_pop),
        .din   (s_din),
        .dout  (in_head),
        .full  (in_full),
        .empty (in_empty),
        .count (in_count)
    );

    fact_fifo #(.WIDTH(RES_W), .DEPTH(DEPTH)) u_out_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (opclear_w),
        .push  (out_push),
        .pop   (out_pop),
        .din   (acc),
        .dout  (out_head),
        .full  (out_full),
        .empty (out_empty),
        .count (out_count)
    );

`ifdef FACTO_OVF_DETECT_EN
    logic [RES_W+DATA_W-1:0] wide;
    assign wide     = {{DATA_W{1'b0}}, acc} * {{RES_W{1'b0}}, cnt};
    assign prod     = wide[RES_W-1:0];
    assign prod_ovf = |wide[RES_W+DATA_W-1:RES_W];
`else
    assign prod     = acc * RES_W'(cnt);
    assign prod_ovf = 1'b0;
`endif

    // cnt captures the operand at the pop so LOAD only has to seed acc.
    always_ff @(posedge clk) begin
        if (reset || opclear_w) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_pop) begin
                        cnt   <= in_head;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    acc   <= RES_W'(1);
                    state <= (cnt <= DATA_W'(1)) ? WRITE : MUL;
                end
                MUL: begin
                    acc <= prod;
                    cnt <= cnt - DATA_W'(1);
                    if (cnt == DATA_W'(2)) state <= WRITE;
                end
                WRITE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            run      <= 1'b0;
            all_done <= 1'b0;
            intr_en  <= 1'b0;
            ovf      <= 1'b0;
            drop     <= 1'b0;
        end else begin
            if (intr_w) intr_en <= s_din[0];
            if (opclear_w) begin
                run      <= 1'b0;
                all_done <= 1'b0;
                ovf      <= 1'b0;
                drop     <= 1'b0;
            end else begin
                if (opstart_w) run <= 1'b1;
                if (operand_w && in_full) drop <= 1'b1;
                if ((state == MUL) && prod_ovf) ovf <= 1'b1;
                if (opstart_w || (in_push && run)) begin
                    all_done <= 1'b0;
                end else if ((state == WRITE) && in_empty && !in_push) begin
                    all_done <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        status               = '0;
        status[ST_ALL_DONE]  = all_done;
        status[ST_BUSY]      = (state != IDLE);
        status[ST_IN_FULL]   = in_full;
        status[ST_OUT_EMPTY] = out_empty;
        status[ST_OVF]       = ovf;
        status[ST_DROP]      = drop;
        status[ST_IN_CNT +: 8]  = 8'(in_count);
        status[ST_OUT_CNT +: 8] = 8'(out_count);
        rdata = '0;
        case (ofs)
            OFS_STATUS:   rdata = status;
            OFS_INTR_EN:  rdata = DATA_W'(intr_en);
            OFS_RESULT_H: rdata = out_empty ? '0 : DATA_W'(out_head >> DATA_W);
            OFS_RESULT_L: rdata = out_empty ? '0 : out_head[DATA_W-1:0];
            default:      rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) s_dout <= '0;
        else       s_dout <= rd_en ? rdata : '0;
    end

endmodule

// File: doc/fact_queue_core.md
# fact_queue_core

Queued, parametrised successor to the memory-mapped factorial core. A bus slave with a register window at BASE_ADDR accepts operands into an input FIFO. A single iterative multiply engine drains that FIFO and pushes RES_W-bit results into an output FIFO. Software reads and pops results, and a level interrupt reports queue completion.

## Interface
- BASE_ADDR, 16'h7000: base of the register window; bits [15:6] are decoded.
- DATA_W, 64: bus width and operand width.
- RES_W, 2*DATA_W: result width, read as two DATA_W halves.
- DEPTH, 4: entries per FIFO; must be a power of two, at least 2.
- clk, input, 1: single clock; all logic is on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- s_sel, input, 1: slave select.
- s_wr, input, 1: 1 selects write, 0 selects read.
- s_addr, input, 16: byte address, 8-byte aligned.
- s_din, input, DATA_W: write data.
- s_dout, output, DATA_W: registered read data.
- interrupt, output, 1: level interrupt, equal to intr_en & all_done.

## Operation
- Register offsets:
  - 0x00 OPSTART (W): bit0 = 1 sets run.
  - 0x08 OPCLEAR (W): bit0 = 1 clears run and all_done, flushes both FIFOs, clears the sticky flags and forces the engine to IDLE.
  - 0x10 STATUS (R): bit0 all_done, bit1 busy (engine not IDLE), bit2 in_full, bit3 out_empty, bit4 ovf, bit5 drop, [15:8] in_count, [23:16] out_count.
  - 0x18 INTR_EN (R/W): bit0.
  - 0x20 OPERAND (W): pushes s_din. If the input FIFO is full, the push is discarded and drop is set.
  - 0x28 RESULT_H (R): head result [RES_W-1:DATA_W].
  - 0x30 RESULT_L (R): head result [DATA_W-1:0].
  - 0x38 RESULT_POP (W): bit0 = 1 pops the output FIFO; no effect when the FIFO is empty.
- Reads of an empty output FIFO, of write-only registers or of unmapped offsets return 0. Writes to read-only or unmapped offsets are ignored.
- A write takes effect only when s_sel = 1 and s_wr = 1. A held write acts once per cycle, so a held OPERAND write pushes every cycle.
- OPSTART while run = 1 has no effect, except that it clears all_done.
- Engine FSM states: IDLE, LOAD, MUL, WRITE.
  - IDLE -> LOAD when run, the input FIFO is non-empty and the output FIFO is not full. The operand n is popped in this cycle.
  - LOAD: acc <= 1, cnt <= n. If n <= 1, go to WRITE; otherwise go to MUL.
  - MUL: acc <= (acc * cnt) truncated to RES_W, and cnt <= cnt - 1. Leave for WRITE on the cycle that multiplies by 2.
  - WRITE: push acc to the output FIFO and return to IDLE.
  - all_done is set in WRITE when the input FIFO is empty and no OPERAND push occurs in the same cycle.
- all_done is cleared by OPSTART, by OPCLEAR, or by an OPERAND push while run = 1.
- Arithmetic: operand n is unsigned DATA_W, with 0! = 1! = 1. Results are taken modulo 2^RES_W.
- Simultaneous events:
  - OPCLEAR beats an engine pop or push and any OPERAND push in the same cycle.
  - A pop and a push of the same FIFO in one cycle are both honoured, and the count is unchanged.

## Timing
- Reset values: s_dout = 0, interrupt = 0, run = 0, intr_en = 0, all_done = 0, FIFOs empty, ovf = 0, drop = 0, FSM in IDLE.
- s_dout is updated one cycle after a read cycle and is 0 after any non-read cycle.
- Per job, from the pop cycle in IDLE to the WRITE cycle:
  - 2 cycles for n <= 1.
  - n + 1 cycles for n >= 2.
  - The result is visible at the FIFO head the cycle after WRITE.
- interrupt rises the cycle after the WRITE that sets all_done.
- When the output FIFO is full, the engine stalls in IDLE and the input FIFO keeps its contents.
- Reset or OPCLEAR mid-job discards the job; the FSM is in IDLE the next cycle.

## Configuration
- FACTO_OVF_DETECT_EN defined:
  - In MUL, the product is computed at RES_W + DATA_W bits.
  - Any nonzero discarded high bit sets the sticky ovf flag.
  - The result is still truncated.
- FACTO_OVF_DETECT_EN undefined: no wide product is built, and STATUS bit4 reads 0.

## Structure
- Package fact_pkg holds:
  - the register offset constants (OFS_OPSTART to OFS_RESULT_POP);
  - the STATUS bit-index constants;
  - the engine state typedef (IDLE, LOAD, MUL, WRITE).
- Sub-module fact_fifo: synchronous FIFO parametrised by width and DEPTH, with push/pop/full/empty/count outputs. It is instantiated twice: for operands at DATA_W and for results at RES_W.

## Test plan
- Push operand 5, set INTR_EN = 1, then OPSTART -> the job completes 6 cycles after the pop; RESULT_L = 120, RESULT_H = 0; interrupt = 1; STATUS bit0 = 1.
- Push 5, 10, 0, 1, then OPSTART -> results pop in order as 120, 3628800, 1, 1; all_done is set only after the fourth result.
- Push operand 35 with FACTO_OVF_DETECT_EN and DATA_W = 64 -> ovf = 1, and the result equals 35! mod 2^128. Push 34 -> ovf stays 0, and the result equals 34! exactly.
- With DEPTH = 4 and run = 0, push 6 operands -> in_count = 4, drop = 1; the fifth and sixth operands are lost.
- Fill the output FIFO without popping -> the engine stalls with busy = 0 and in_count unchanged; one RESULT_POP releases exactly one further job.
- Push 20, OPSTART, then OPCLEAR or reset during MUL -> next cycle busy = 0, both FIFOs are empty, interrupt = 0, and no result is pushed.
